// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the store buffer.
//   sb_state_t         per-entry lifecycle state
//   SB_DEPTH_DEFAULT   default entry count (power of two, >= 2)
package store_buffer_pkg;

    localparam int unsigned SB_DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        SB_FREE   = 2'd0,
        SB_ALLOC  = 2'd1,
        SB_READY  = 2'd2,
        SB_COMMIT = 2'd3
    } sb_state_t;

endpackage

// File: rtl/store_buffer.sv
// Store buffer: allocates stores in program order, fills them out of order
// from writeback, commits them in order at retirement and drains committed
// stores in order to data memory. Flush discards speculative entries.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush                         discard all uncommitted entries
//   alloc_valid/alloc_rob_id      allocate one entry at tail
//   alloc_ready                   an entry is free
//   fill_valid/_rob_id/_addr/_data  complete address/data of an allocated store
//   retire_valid/retire_rob_id    commit the oldest uncommitted store
//   mem_wvalid/_waddr/_wdata      write request for the head entry
//   mem_wready                    memory accepts the write
//   sb_empty                      no valid entries
//   sb_error                      sticky protocol error (bad retire)
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROB_WIDTH  = 5,
    parameter int unsigned SB_DEPTH   = SB_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alloc_valid,
    input  logic [ROB_WIDTH-1:0]  alloc_rob_id,
    output logic                  alloc_ready,
    input  logic                  fill_valid,
    input  logic [ROB_WIDTH-1:0]  fill_rob_id,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  retire_valid,
    input  logic [ROB_WIDTH-1:0]  retire_rob_id,
    output logic                  mem_wvalid,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_wready,
    output logic                  sb_empty,
    output logic                  sb_error
);

    localparam int unsigned PW = $clog2(SB_DEPTH);
    localparam int unsigned CW = PW + 1;

    sb_state_t             state_q [SB_DEPTH];
    sb_state_t             state_n [SB_DEPTH];
    logic [ROB_WIDTH-1:0]  tag_q   [SB_DEPTH];
    logic [ROB_WIDTH-1:0]  tag_n   [SB_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q  [SB_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_n  [SB_DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [SB_DEPTH];
    logic [DATA_WIDTH-1:0] data_n  [SB_DEPTH];

    logic [PW-1:0] head_q, head_n;
    logic [PW-1:0] cptr_q, cptr_n;
    logic [PW-1:0] tail_q, tail_n;
    logic [CW-1:0] count_q, count_n;
    logic          error_n;
    logic          retire_ok;
    logic          drain;
    logic          alloc_ok;

    // Next-state: drain and retire first, then either flush or fill/alloc.
    always_comb begin
        state_n   = state_q;
        tag_n     = tag_q;
        addr_n    = addr_q;
        data_n    = data_q;
        head_n    = head_q;
        cptr_n    = cptr_q;
        tail_n    = tail_q;
        count_n   = '0;
        error_n   = sb_error;
        retire_ok = retire_valid && (state_q[cptr_q] == SB_READY)
                    && (tag_q[cptr_q] == retire_rob_id);
        drain     = (state_q[head_q] == SB_COMMIT) && mem_wready;
        alloc_ok  = alloc_valid && (count_q != CW'(SB_DEPTH));

        if (retire_valid && !retire_ok) begin
            error_n = 1'b1;
        end

        if (drain) begin
            state_n[head_q] = SB_FREE;
            head_n          = head_q + PW'(1);
        end

        if (retire_ok) begin
            state_n[cptr_q] = SB_COMMIT;
            cptr_n          = cptr_q + PW'(1);
        end

        if (flush) begin
            // Speculative entries vanish; committed ones keep draining.
            for (int i = 0; i < int'(SB_DEPTH); i++) begin
                if (state_n[i] == SB_ALLOC || state_n[i] == SB_READY) begin
                    state_n[i] = SB_FREE;
                end
            end
            tail_n = cptr_n;
        end else begin
            // Fill CAM: only entries still waiting for data can match.
            for (int i = 0; i < int'(SB_DEPTH); i++) begin
                if (fill_valid && state_q[i] == SB_ALLOC && tag_q[i] == fill_rob_id) begin
                    state_n[i] = SB_READY;
                    addr_n[i]  = fill_addr;
                    data_n[i]  = fill_data;
                end
            end
            if (alloc_ok) begin
                state_n[tail_q] = SB_ALLOC;
                tag_n[tail_q]   = alloc_rob_id;
                tail_n          = tail_q + PW'(1);
            end
        end

        for (int i = 0; i < int'(SB_DEPTH); i++) begin
            if (state_n[i] != SB_FREE) begin
                count_n = count_n + CW'(1);
            end
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= '{default: SB_FREE};
            head_q      <= '0;
            cptr_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            alloc_ready <= 1'b1;
            sb_empty    <= 1'b1;
            mem_wvalid  <= 1'b0;
            mem_waddr   <= '0;
            mem_wdata   <= '0;
            sb_error    <= 1'b0;
        end else begin
            state_q     <= state_n;
            head_q      <= head_n;
            cptr_q      <= cptr_n;
            tail_q      <= tail_n;
            count_q     <= count_n;
            alloc_ready <= (count_n != CW'(SB_DEPTH));
            sb_empty    <= (count_n == '0);
            mem_wvalid  <= (state_n[head_n] == SB_COMMIT);
            mem_waddr   <= addr_n[head_n];
            mem_wdata   <= data_n[head_n];
            sb_error    <= error_n;
        end
    end

    // Payload storage; contents are only meaningful while the entry is valid.
    always_ff @(posedge clk) begin
        tag_q  <= tag_n;
        addr_q <= addr_n;
        data_q <= data_n;
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        alloc_valid;
    logic [4:0]  alloc_rob_id;
    logic        alloc_ready;
    logic        fill_valid;
    logic [4:0]  fill_rob_id;
    logic [31:0] fill_addr;
    logic [31:0] fill_data;
    logic        retire_valid;
    logic [4:0]  retire_rob_id;
    logic        mem_wvalid;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wready;
    logic        sb_empty;
    logic        sb_error;

    int tests = 0;
    int fails = 0;

    store_buffer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ROB_WIDTH(5), .SB_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_rob_id(alloc_rob_id), .alloc_ready(alloc_ready),
        .fill_valid(fill_valid), .fill_rob_id(fill_rob_id),
        .fill_addr(fill_addr), .fill_data(fill_data),
        .retire_valid(retire_valid), .retire_rob_id(retire_rob_id),
        .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wready(mem_wready), .sb_empty(sb_empty), .sb_error(sb_error)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic [4:0] tag);
        alloc_valid = 1'b1; alloc_rob_id = tag;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_fill(input logic [4:0] tag, input logic [31:0] a, input logic [31:0] d);
        fill_valid = 1'b1; fill_rob_id = tag; fill_addr = a; fill_data = d;
        tick();
        fill_valid = 1'b0;
    endtask

    task automatic do_retire(input logic [4:0] tag);
        retire_valid = 1'b1; retire_rob_id = tag;
        tick();
        retire_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_rob_id = '0;
        fill_valid = 1'b0; fill_rob_id = '0; fill_addr = '0; fill_data = '0;
        retire_valid = 1'b0; retire_rob_id = '0; mem_wready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL reset_alloc_ready got %b exp 1", alloc_ready); end
        tests++; if (sb_empty !== 1'b1) begin fails++; $display("FAIL reset_sb_empty got %b exp 1", sb_empty); end
        tests++; if (mem_wvalid !== 1'b0) begin fails++; $display("FAIL reset_mem_wvalid got %b exp 0", mem_wvalid); end
        tests++; if (mem_waddr !== 32'h0) begin fails++; $display("FAIL reset_mem_waddr got %h exp 0", mem_waddr); end
        tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
        tests++; if (sb_error !== 1'b0) begin fails++; $display("FAIL reset_sb_error got %b exp 0", sb_error); end
    endtask

    // Out-of-order fill, in-order retire and drain.
    task automatic test_in_order();
        mem_wready = 1'b1;
        do_alloc(5'd3);
        do_alloc(5'd4);
        tests++; if (sb_empty !== 1'b0) begin fails++; $display("FAIL order_not_empty got %b exp 0", sb_empty); end
        do_fill(5'd4, 32'h100, 32'hAA);
        do_fill(5'd3, 32'h104, 32'hBB);
        tests++; if (mem_wvalid !== 1'b0) begin fails++; $display("FAIL order_no_write_before_retire got %b exp 0", mem_wvalid); end
        do_retire(5'd3);
        tests++; if (mem_wvalid !== 1'b1 || mem_waddr !== 32'h104 || mem_wdata !== 32'hBB) begin
            fails++; $display("FAIL order_first_write got v=%b a=%h d=%h exp v=1 a=104 d=bb", mem_wvalid, mem_waddr, mem_wdata); end
        do_retire(5'd4);
        tests++; if (mem_wvalid !== 1'b1 || mem_waddr !== 32'h100 || mem_wdata !== 32'hAA) begin
            fails++; $display("FAIL order_second_write got v=%b a=%h d=%h exp v=1 a=100 d=aa", mem_wvalid, mem_waddr, mem_wdata); end
        tick();
        tests++; if (mem_wvalid !== 1'b0 || sb_empty !== 1'b1) begin
            fails++; $display("FAIL order_drained got v=%b empty=%b exp v=0 empty=1", mem_wvalid, sb_empty); end
    endtask

    // Fill to capacity, refused alloc during drain, pointer wrap.
    task automatic test_full_wrap();
        mem_wready = 1'b0;
        for (int i = 0; i < 8; i++) do_alloc(5'(10 + i));
        tests++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL full_alloc_ready got %b exp 0", alloc_ready); end
        for (int i = 0; i < 8; i++) do_fill(5'(10 + i), 32'h200 + 32'(4 * i), 32'h1000 + 32'(i));
        for (int i = 0; i < 8; i++) do_retire(5'(10 + i));
        tests++; if (mem_wvalid !== 1'b1 || mem_waddr !== 32'h200) begin
            fails++; $display("FAIL full_head got v=%b a=%h exp v=1 a=200", mem_wvalid, mem_waddr); end
        // Drain one while alloc is held: refused this cycle, accepted next.
        alloc_valid = 1'b1; alloc_rob_id = 5'd18; mem_wready = 1'b1;
        tick();
        mem_wready = 1'b0;
        tests++; if (alloc_ready !== 1'b1 || mem_waddr !== 32'h204) begin
            fails++; $display("FAIL full_refused got ready=%b a=%h exp ready=1 a=204", alloc_ready, mem_waddr); end
        tick();
        alloc_valid = 1'b0;
        tests++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL full_accept_next got %b exp 0", alloc_ready); end
        do_fill(5'd18, 32'h300, 32'h2000);
        do_retire(5'd18);
        mem_wready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ea;
            logic [31:0] ed;
            ea = (i < 7) ? 32'h204 + 32'(4 * i) : 32'h300;
            ed = (i < 7) ? 32'h1001 + 32'(i) : 32'h2000;
            tests++; if (mem_wvalid !== 1'b1 || mem_waddr !== ea || mem_wdata !== ed) begin
                fails++; $display("FAIL wrap_drain_%0d got v=%b a=%h d=%h exp v=1 a=%h d=%h", i, mem_wvalid, mem_waddr, mem_wdata, ea, ed); end
            tick();
        end
        tests++; if (mem_wvalid !== 1'b0 || sb_empty !== 1'b1 || sb_error !== 1'b0) begin
            fails++; $display("FAIL wrap_end got v=%b empty=%b err=%b exp 0 1 0", mem_wvalid, sb_empty, sb_error); end
    endtask

    // Flush keeps the committed store only; tail returns to after it.
    task automatic test_flush();
        mem_wready = 1'b0;
        do_alloc(5'd5); do_alloc(5'd6); do_alloc(5'd7);
        do_fill(5'd5, 32'h400, 32'h55);
        do_fill(5'd6, 32'h404, 32'h66);
        do_fill(5'd7, 32'h408, 32'h77);
        do_retire(5'd5);
        flush = 1'b1; tick(); flush = 1'b0;
        tests++; if (mem_wvalid !== 1'b1 || mem_waddr !== 32'h400 || sb_empty !== 1'b0 || alloc_ready !== 1'b1) begin
            fails++; $display("FAIL flush_keep got v=%b a=%h empty=%b ready=%b exp 1 400 0 1", mem_wvalid, mem_waddr, sb_empty, alloc_ready); end
        mem_wready = 1'b1;
        tick();
        tests++; if (mem_wvalid !== 1'b0 || sb_empty !== 1'b1) begin
            fails++; $display("FAIL flush_empty got v=%b empty=%b exp 0 1", mem_wvalid, sb_empty); end
        do_alloc(5'd8);
        do_fill(5'd8, 32'h500, 32'h88);
        do_retire(5'd8);
        tests++; if (mem_wvalid !== 1'b1 || mem_waddr !== 32'h500 || mem_wdata !== 32'h88 || sb_error !== 1'b0) begin
            fails++; $display("FAIL flush_reuse got v=%b a=%h d=%h err=%b exp 1 500 88 0", mem_wvalid, mem_waddr, mem_wdata, sb_error); end
        tick();
    endtask

    // Write held stable under backpressure.
    task automatic test_backpressure();
        mem_wready = 1'b0;
        do_alloc(5'd20);
        do_fill(5'd20, 32'h600, 32'hDEAD);
        do_retire(5'd20);
        for (int i = 0; i < 4; i++) begin
            tests++; if (mem_wvalid !== 1'b1 || mem_waddr !== 32'h600 || mem_wdata !== 32'hDEAD) begin
                fails++; $display("FAIL hold_%0d got v=%b a=%h d=%h exp 1 600 dead", i, mem_wvalid, mem_waddr, mem_wdata); end
            tick();
        end
        mem_wready = 1'b1;
        tick();
        tests++; if (mem_wvalid !== 1'b0 || sb_empty !== 1'b1) begin
            fails++; $display("FAIL hold_release got v=%b empty=%b exp 0 1", mem_wvalid, sb_empty); end
    endtask

    // Out-of-order and unfilled retires flag an error without state change.
    task automatic test_error();
        mem_wready = 1'b1;
        do_alloc(5'd8); do_alloc(5'd9);
        do_fill(5'd8, 32'h700, 32'h8); do_fill(5'd9, 32'h704, 32'h9);
        do_retire(5'd9);
        tests++; if (sb_error !== 1'b1 || mem_wvalid !== 1'b0) begin
            fails++; $display("FAIL err_wrong_tag got err=%b v=%b exp 1 0", sb_error, mem_wvalid); end
        do_retire(5'd8);
        tests++; if (mem_wvalid !== 1'b1 || mem_waddr !== 32'h700) begin
            fails++; $display("FAIL err_state_kept got v=%b a=%h exp 1 700", mem_wvalid, mem_waddr); end
        do_retire(5'd9);
        tick();
        do_alloc(5'd30);
        do_retire(5'd30);
        tests++; if (mem_wvalid !== 1'b0 || sb_empty !== 1'b0 || sb_error !== 1'b1) begin
            fails++; $display("FAIL err_unfilled got v=%b empty=%b err=%b exp 0 0 1", mem_wvalid, sb_empty, sb_error); end
        flush = 1'b1; tick(); flush = 1'b0;
        tests++; if (sb_empty !== 1'b1 || sb_error !== 1'b1) begin
            fails++; $display("FAIL err_sticky got empty=%b err=%b exp 1 1", sb_empty, sb_error); end
    endtask

    // Reset mid-drain drops pending writes.
    task automatic test_rst_mid_drain();
        rst = 1'b1; tick(); rst = 1'b0;
        mem_wready = 1'b0;
        for (int i = 1; i <= 3; i++) do_alloc(5'(i));
        for (int i = 1; i <= 3; i++) do_fill(5'(i), 32'h800 + 32'(4 * i), 32'(i));
        for (int i = 1; i <= 3; i++) do_retire(5'(i));
        tests++; if (mem_wvalid !== 1'b1 || mem_waddr !== 32'h804) begin
            fails++; $display("FAIL rst_pending got v=%b a=%h exp 1 804", mem_wvalid, mem_waddr); end
        mem_wready = 1'b1;
        rst = 1'b1; tick(); rst = 1'b0;
        tests++; if (mem_wvalid !== 1'b0 || sb_empty !== 1'b1 || alloc_ready !== 1'b1 || sb_error !== 1'b0 || mem_waddr !== 32'h0) begin
            fails++; $display("FAIL rst_drop got v=%b empty=%b ready=%b err=%b a=%h exp 0 1 1 0 0", mem_wvalid, sb_empty, alloc_ready, sb_error, mem_waddr); end
        tick();
        tests++; if (mem_wvalid !== 1'b0 || sb_empty !== 1'b1) begin
            fails++; $display("FAIL rst_stays_empty got v=%b empty=%b exp 0 1", mem_wvalid, sb_empty); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full_wrap();
        test_flush();
        test_backpressure();
        test_error();
        test_rst_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
